// File: rtl/matvec_sequencer_pkg.sv
// Shared definitions for the matrix-vector datapath: sequencer state encoding
// plus fixed-point width and address-width helpers also used by the engine.
package matvec_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_CLEAR,
        ST_RUN,
        ST_STORE,
        ST_DONE
    } mv_state_e;

    function automatic int fx_bitwidth(input int qn, input int qm);
        return qn + qm + 1;
    endfunction

    // A single-row memory still needs a one-bit address port.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/matvec_sequencer.sv
// Walks the weight rows one at a time through an external dot-product engine:
// IDLE -> FETCH -> LOAD -> CLEAR -> RUN -> STORE (per row) -> DONE -> IDLE.
module matvec_sequencer
    import matvec_sequencer_pkg::*;
#(
    parameter int  N_ROWS    = 16,
    parameter int  ARRAY_LEN = 16,
    parameter int  QN        = 6,
    parameter int  QM        = 11,
    localparam int BITWIDTH  = fx_bitwidth(QN, QM),
    localparam int AW        = addr_width(N_ROWS),
    localparam int VW        = ARRAY_LEN * BITWIDTH,
    localparam int OW        = N_ROWS * BITWIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [VW-1:0]       inputVector,
    output logic [AW-1:0]       weightAddr,
    input  logic [VW-1:0]       weightData,
    output logic [VW-1:0]       engWeightRow,
    output logic [VW-1:0]       engInputVector,
    output logic                engReset,
    input  logic                engDataReady,
    input  logic [BITWIDTH-1:0] engResult,
    output logic [OW-1:0]       outputVector,
    output logic                busy,
    output logic                done
);

    mv_state_e           state_q, state_d;
    logic [AW-1:0]       row_q, row_d;
    logic [VW-1:0]       in_vec_q, in_vec_d;
    logic [VW-1:0]       w_row_q, w_row_d;
    logic [BITWIDTH-1:0] result_q, result_d;
    logic [OW-1:0]       out_vec_q, out_vec_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            in_vec_q  <= '0;
            w_row_q   <= '0;
            result_q  <= '0;
            out_vec_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            in_vec_q  <= in_vec_d;
            w_row_q   <= w_row_d;
            result_q  <= result_d;
            out_vec_q <= out_vec_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        in_vec_d  = in_vec_q;
        w_row_d   = w_row_q;
        result_d  = result_q;
        out_vec_d = out_vec_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    in_vec_d = inputVector;
                    row_d    = '0;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                w_row_d = weightData;
                state_d = ST_CLEAR;
            end
            ST_CLEAR: state_d = ST_RUN;
            ST_RUN: begin
                if (engDataReady) begin
                    result_d = engResult;
                    state_d  = ST_STORE;
                end
            end
            ST_STORE: begin
                out_vec_d[int'(row_q)*BITWIDTH +: BITWIDTH] = result_q;
                // Last-row test comes first so the row counter never wraps.
                if (row_q == AW'(N_ROWS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign weightAddr     = row_q;
    assign engWeightRow   = w_row_q;
    assign engInputVector = in_vec_q;
    assign outputVector   = out_vec_q;
    assign engReset       = (state_q == ST_IDLE) || (state_q == ST_CLEAR) || (state_q == ST_DONE);
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE);

endmodule

// File: tb/tb_matvec_sequencer.sv
// Directed bench for matvec_sequencer with a behavioural weight memory and
// dot-product engine of programmable latency.
module tb_matvec_sequencer;

    localparam int NR = 4;
    localparam int AL = 16;
    localparam int BW = 18;
    localparam int QM = 11;
    localparam int AW = 2;
    localparam int VW = AL * BW;
    localparam int OW = NR * BW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [VW-1:0] inputVector;
    logic [AW-1:0] weightAddr;
    logic [VW-1:0] weightData;
    logic [VW-1:0] engWeightRow;
    logic [VW-1:0] engInputVector;
    logic          engReset;
    logic          engDataReady;
    logic [BW-1:0] engResult;
    logic [OW-1:0] outputVector;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    logic [VW-1:0] mem [NR];
    int            eng_lat;
    int            cnt = 0;
    logic          force_en;
    logic          force_on;
    int            busy_cyc = 0;
    int            done_cyc = 0;
    int            er_cyc   = 0;

    matvec_sequencer #(
        .N_ROWS   (NR),
        .ARRAY_LEN(AL),
        .QN       (6),
        .QM       (QM)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .inputVector   (inputVector),
        .weightAddr    (weightAddr),
        .weightData    (weightData),
        .engWeightRow  (engWeightRow),
        .engInputVector(engInputVector),
        .engReset      (engReset),
        .engDataReady  (engDataReady),
        .engResult     (engResult),
        .outputVector  (outputVector),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] fill(input logic [BW-1:0] v);
        logic [VW-1:0] f;
        for (int i = 0; i < AL; i++) f[i*BW +: BW] = v;
        return f;
    endfunction

    function automatic logic [OW-1:0] pack4(input int e0, input int e1, input int e2, input int e3);
        return {18'(e3), 18'(e2), 18'(e1), 18'(e0)};
    endfunction

    function automatic logic [BW-1:0] dot(input logic [VW-1:0] w, input logic [VW-1:0] x);
        longint acc;
        logic signed [BW-1:0] a, b;
        acc = 0;
        for (int i = 0; i < AL; i++) begin
            a = w[i*BW +: BW];
            b = x[i*BW +: BW];
            acc += longint'(a) * longint'(b);
        end
        acc = acc >>> QM;
        return acc[BW-1:0];
    endfunction

    // Weight memory: registered read, data one cycle after the address.
    always @(posedge clk) weightData <= mem[weightAddr];

    // Engine: cleared while engReset is high, result valid after eng_lat cycles.
    always @(posedge clk) begin
        if (engReset) cnt <= 0;
        else if (cnt < eng_lat) cnt <= cnt + 1;
    end
    assign force_on     = force_en && engReset && busy;
    assign engDataReady = (!engReset && cnt == eng_lat) || force_on;
    assign engResult    = force_on ? 18'h15555 : dot(engWeightRow, engInputVector);

    always @(negedge clk) begin
        if (busy) busy_cyc++;
        if (done) done_cyc++;
        if (busy && engReset) er_cyc++;
    end

    task automatic load_mem(input int scale);
        for (int r = 0; r < NR; r++) mem[r] = fill(18'(scale * (r + 1)));
    endtask

    task automatic pulse_start(input logic [VW-1:0] v);
        @(negedge clk);
        inputVector = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (engReset !== 1'b1) begin errors++; $display("FAIL reset_engReset: got %b expected 1", engReset); end
        checks++; if (outputVector !== '0) begin errors++; $display("FAIL reset_out: got %h expected 0", outputVector); end
        checks++; if (weightAddr !== '0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", weightAddr); end
        checks++; if (engWeightRow !== '0) begin errors++; $display("FAIL reset_wrow: got %h expected 0", engWeightRow); end
        checks++; if (engInputVector !== '0) begin errors++; $display("FAIL reset_ivec: got %h expected 0", engInputVector); end
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int b0, d0, e0;
        bit ok;
        load_mem(128);
        eng_lat = 3;
        b0 = busy_cyc; d0 = done_cyc; e0 = er_cyc;
        pulse_start(fill(18'd2048));
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: busy still %b, required 0", busy); end
        checks++; if (outputVector !== pack4(2048, 4096, 6144, 8192)) begin errors++; $display("FAIL basic_out: got %h expected %h", outputVector, pack4(2048, 4096, 6144, 8192)); end
        checks++; if (done_cyc - d0 != 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", done_cyc - d0); end
        checks++; if (busy_cyc - b0 != 33) begin errors++; $display("FAIL basic_latency: got %0d busy cycles expected 33", busy_cyc - b0); end
        checks++; if (er_cyc - e0 != 5) begin errors++; $display("FAIL basic_engreset_cycles: got %0d expected 5", er_cyc - e0); end
        checks++; if (engInputVector !== fill(18'd2048)) begin errors++; $display("FAIL basic_ivec: got %h expected %h", engInputVector, fill(18'd2048)); end
    endtask

    task automatic test_start_ignored;
        int b0, d0;
        bit ok;
        load_mem(256);
        eng_lat = 2;
        d0 = done_cyc;
        pulse_start(fill(18'd2048));
        repeat (5) @(negedge clk);
        inputVector = fill(18'd4096);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ignore_timeout: busy still %b, required 0", busy); end
        checks++; if (outputVector !== pack4(4096, 8192, 12288, 16384)) begin errors++; $display("FAIL ignore_out: got %h expected %h", outputVector, pack4(4096, 8192, 12288, 16384)); end
        checks++; if (engInputVector !== fill(18'd2048)) begin errors++; $display("FAIL ignore_ivec: got %h expected %h", engInputVector, fill(18'd2048)); end
        checks++; if (done_cyc - d0 != 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", done_cyc - d0); end
        b0 = busy_cyc;
        repeat (20) @(negedge clk);
        checks++; if (busy_cyc - b0 != 0) begin errors++; $display("FAIL ignore_restart: got %0d busy cycles expected 0", busy_cyc - b0); end
    endtask

    task automatic test_clear_ready;
        int b0;
        bit ok;
        load_mem(64);
        eng_lat = 0;
        force_en = 1'b1;
        b0 = busy_cyc;
        pulse_start(fill(18'd2048));
        wait_idle(200, ok);
        force_en = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL clear_timeout: busy still %b, required 0", busy); end
        checks++; if (outputVector !== pack4(1024, 2048, 3072, 4096)) begin errors++; $display("FAIL clear_out: got %h expected %h", outputVector, pack4(1024, 2048, 3072, 4096)); end
        checks++; if (busy_cyc - b0 != 21) begin errors++; $display("FAIL clear_latency: got %0d busy cycles expected 21", busy_cyc - b0); end
    endtask

    task automatic test_reset_mid;
        int d0, b0;
        bit ok;
        load_mem(32);
        eng_lat = 5;
        d0 = done_cyc;
        pulse_start(fill(18'd2048));
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (weightAddr == 2'd2) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        for (int i = 0; i < 100 && ok; i++) begin
            if (engReset) break;
            @(negedge clk);
        end
        for (int i = 0; i < 100 && ok; i++) begin
            if (!engReset) break;
            @(negedge clk);
        end
        checks++; if (!ok || engReset !== 1'b0) begin errors++; $display("FAIL mid_reach_run: addr %0d engReset %b, required addr 2 in RUN", weightAddr, engReset); end
        checks++; if (outputVector[0 +: 36] !== {18'd1024, 18'd512}) begin errors++; $display("FAIL mid_partial: got %h expected %h", outputVector[0 +: 36], {18'd1024, 18'd512}); end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (outputVector !== '0) begin errors++; $display("FAIL mid_out: got %h expected 0", outputVector); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
        checks++; if (engReset !== 1'b1) begin errors++; $display("FAIL mid_engReset: got %b expected 1", engReset); end
        @(negedge clk);
        reset = 1'b1;
        b0 = busy_cyc;
        repeat (40) @(negedge clk);
        checks++; if (done_cyc - d0 != 0) begin errors++; $display("FAIL mid_no_done: got %0d done pulses expected 0", done_cyc - d0); end
        checks++; if (busy_cyc - b0 != 0) begin errors++; $display("FAIL mid_resume: got %0d busy cycles expected 0", busy_cyc - b0); end
    endtask

    task automatic test_negative;
        int b0;
        bit ok;
        for (int r = 0; r < NR; r++) mem[r] = fill(18'h3F800);
        eng_lat = 1;
        b0 = busy_cyc;
        pulse_start(fill(18'd2048));
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL neg_timeout: busy still %b, required 0", busy); end
        checks++; if (outputVector !== {4{18'h38000}}) begin errors++; $display("FAIL neg_out: got %h expected %h", outputVector, {4{18'h38000}}); end
        checks++; if (busy_cyc - b0 != 25) begin errors++; $display("FAIL neg_latency: got %0d busy cycles expected 25", busy_cyc - b0); end
    endtask

    task automatic test_back_to_back;
        int d0;
        bit ok;
        load_mem(128);
        eng_lat = 2;
        pulse_start(fill(18'd2048));
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL b2b_first_done: done %b, required a pulse", done); end
        @(negedge clk);
        d0 = done_cyc;
        inputVector = fill(18'd4096);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (weightAddr == 2'd1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!ok || engInputVector !== fill(18'd4096)) begin errors++; $display("FAIL b2b_second_latch: got %h expected %h", engInputVector, fill(18'd4096)); end
        checks++; if ({outputVector[54 +: 18], outputVector[0 +: 18]} !== {18'd8192, 18'd4096}) begin errors++; $display("FAIL b2b_row_by_row: got %h expected %h", {outputVector[54 +: 18], outputVector[0 +: 18]}, {18'd8192, 18'd4096}); end
        wait_idle(200, ok);
        checks++; if (!ok || outputVector !== pack4(4096, 8192, 12288, 16384)) begin errors++; $display("FAIL b2b_out: got %h expected %h", outputVector, pack4(4096, 8192, 12288, 16384)); end
        checks++; if (done_cyc - d0 != 1) begin errors++; $display("FAIL b2b_done_count: got %0d expected 1", done_cyc - d0); end
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        inputVector = '0;
        eng_lat     = 3;
        force_en    = 1'b0;
        for (int r = 0; r < NR; r++) mem[r] = '0;
        test_reset();
        test_basic();
        test_start_ignored();
        test_clear_ready();
        test_reset_mid();
        test_negative();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
